// File: rtl/shift_reg_iter.sv
// shift_reg_iter: iterative 1-bit-per-clock shifter with start/busy/done handshake.
// Define SHIFT_ROTATE_EN to enable the ROR/ROL datapath; otherwise those ops act as NOP.
module shift_reg_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
`ifdef SHIFT_ROTATE_EN
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       op_q, op_nx;
    logic [WIDTH-1:0] data_nx, step;
    logic             rot_op, shift_op;

`ifdef SHIFT_ROTATE_EN
    assign rot_op = (op == OP_ROR) || (op == OP_ROL);
`else
    assign rot_op = 1'b0;
`endif
    assign shift_op = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || rot_op;

    // One-bit step of the latched operation
    always_comb begin
        step = data_out;
        case (op_q)
            OP_SLL:  step = {data_out[WIDTH-2:0], 1'b0};
            OP_SRL:  step = {1'b0, data_out[WIDTH-1:1]};
            OP_SRA:  step = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
            OP_ROR:  step = {data_out[0], data_out[WIDTH-1:1]};
            OP_ROL:  step = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
`endif
            default: step = data_out;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op_q;
        data_nx  = data_out;
        case (state)
            IDLE: if (start) begin
                state_nx = DONE;
                if (op == OP_LOAD) data_nx = data_in;
                else if (shift_op && n != '0) begin
                    state_nx = SHIFT;
                    op_nx    = op;
                    cnt_nx   = n;
                end
            end
            SHIFT: begin
                data_nx  = step;
                cnt_nx   = cnt - 1'b1;
                state_nx = (cnt == CNT_W'(1)) ? DONE : SHIFT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            op_q     <= op_nx;
            data_out <= data_nx;
            busy     <= (state_nx == SHIFT);
            done     <= (state_nx == DONE);
        end
    end
endmodule

// File: tb/tb_shift_reg_iter.sv
// tb_shift_reg_iter: directed and random commands checked against an arithmetic reference model.
module tb_shift_reg_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [4:0]  n = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        busy, done;
    logic [31:0] exp_d = '0;
    int          tests = 0;
    int          fails = 0;

    shift_reg_iter #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .n(n),
        .data_in(data_in), .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

`ifdef SHIFT_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    function automatic bit is_sh(input logic [2:0] o);
        return (o inside {3'd2, 3'd3, 3'd4}) || (ROT && (o inside {3'd5, 3'd6}));
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [4:0] k,
                                            input logic [31:0] d, input logic [31:0] din);
        logic [63:0] dd;
        int r;
        r = k % 32;
        case (o)
            3'd1: return din;
            3'd2: return d << k;
            3'd3: return d >> k;
            3'd4: return $signed(d) >>> k;
            3'd5: begin dd = {d, d} >> r; return ROT ? dd[31:0] : d; end
            3'd6: begin dd = {d, d} << r; return ROT ? dd[63:32] : d; end
            default: return d;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // noise: 0 quiet, 1 random inputs while busy, 2 LOAD 0xDEADBEEF strobes while busy
    task automatic cmd(input logic [2:0] o, input logic [4:0] k, input logic [31:0] d, input int noise);
        int lat, bcnt, got;
        logic [31:0] e;
        e   = ref_res(o, k, exp_d, d);
        lat = (is_sh(o) && k != 0) ? k + 1 : 1;
        @(negedge clk);
        start = 1'b1; op = o; n = k; data_in = d;
        got = 0; bcnt = 0;
        for (int i = 1; i <= 40 && got == 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && noise == 1) begin
                start = 1'($urandom); op = 3'($urandom); n = 5'($urandom); data_in = $urandom;
            end
            if (busy && noise == 2) begin
                start = 1'b1; op = 3'd1; data_in = 32'hDEAD_BEEF;
            end
            if (busy) bcnt++;
            if (done) got = i;
        end
        start = 1'b0;
        check("done_latency", got, lat);
        check("busy_cycles", bcnt, lat - 1);
        check("result", data_out, e);
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
        exp_d = e;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        check("reset_data", data_out, 32'd0);
        check("reset_flags", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // reset mid-SHIFT aborts without done
        cmd(3'd1, 5'd0, 32'hA5A5_1234, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; n = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_data", data_out, 32'd0);
        check("abort_flags", {30'd0, busy, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {30'd0, busy, done}, 32'd0);
        end
        reset = 1'b0;
        exp_d = '0;
        cmd(3'd1, 5'd0, 32'h0BAD_F00D, 0);
        check("load_after_abort", data_out, 32'h0BAD_F00D);

        cmd(3'd1, 5'd0, 32'h8000_00F0, 0);
        check("load_const", data_out, 32'h8000_00F0);
        cmd(3'd4, 5'd4, 32'h0, 0);
        check("sra4_const", data_out, 32'hF800_000F);

        cmd(3'd1, 5'd0, 32'h0000_0001, 0);
        cmd(3'd2, 5'd31, 32'h0, 0);
        check("sll31_const", data_out, 32'h8000_0000);
        cmd(3'd3, 5'd31, 32'h0, 0);
        check("srl31_const", data_out, 32'h0000_0001);

        cmd(3'd3, 5'd0, 32'hFFFF_FFFF, 0);
        cmd(3'd0, 5'd9, 32'hFFFF_FFFF, 0);
        cmd(3'd7, 5'd5, 32'hFFFF_FFFF, 0);
        check("nop_unchanged", data_out, 32'h0000_0001);

        cmd(3'd1, 5'd0, 32'h0000_0F0F, 0);
        cmd(3'd2, 5'd3, 32'h0, 2);
        check("sll3_ignores_start", data_out, 32'h0000_7878);

        cmd(3'd1, 5'd0, 32'h1234_5678, 0);
        cmd(3'd5, 5'd8, 32'h0, 0);
        check("ror8_const", data_out, ROT ? 32'h7812_3456 : 32'h1234_5678);
        cmd(3'd6, 5'd12, 32'h0, 1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(1, 7));
            if (i % 4 == 0) o = 3'd1;
            cmd(o, 5'($urandom), $urandom, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
